// File: rtl/xor_mask_pkg.sv
// Shared definitions for the masked-XOR pipeline: width defaults, the S1 stage
// record and the parity helper.
package xor_mask_pkg;

  localparam int WIDTH_DEFAULT = 8;
  localparam int MAX_WIDTH     = 64;

  // Data fields are held at the maximum width; bits above WIDTH are always zero.
  typedef struct packed {
    logic                 valid;
    logic                 acc_en;
    logic [MAX_WIDTH-1:0] x;
    logic [MAX_WIDTH-1:0] am;
    logic [MAX_WIDTH-1:0] m;
  } s1_rec_t;

  function automatic logic parity_of(input logic [MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/xor_mask_core.sv
// Per-beat combinational function between S1 and S2: mask the XOR term, then
// fold in the pre-masked operand B.
module xor_mask_core
  import xor_mask_pkg::*;
#(
  parameter int W = MAX_WIDTH
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] am,
  input  logic [W-1:0] m,
  output logic [W-1:0] r
);

  logic [W-1:0] masked_s;

  always_comb begin
    masked_s = x & m;
    r        = masked_s ^ am;
  end

endmodule

// File: rtl/xor_mask_pipe.sv
// Two-stage valid/ready pipeline computing ((in1^in2)&m)^(in2&m) with an
// optional running XOR accumulator applied at the output stage.
module xor_mask_pipe
  import xor_mask_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             parity
);

  localparam int MW = MAX_WIDTH;

  logic [WIDTH-1:0] m_q, m_d;
  s1_rec_t          s1_q, s1_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_acc_en_q, s2_acc_en_d;
  logic [MW-1:0]    s2_r_q, s2_r_d;
  logic [MW-1:0]    out_q, out_d;
  logic             parity_q, parity_d;
  logic [MW-1:0]    acc_q, acc_d;
  logic [MW-1:0]    r_s;
  logic             s2_adv_s;
  logic             xfer_s;

  xor_mask_core #(.W(MW)) u_core (
    .x  (s1_q.x),
    .am (s1_q.am),
    .m  (s1_q.m),
    .r  (r_s)
  );

  always_comb begin
    s2_adv_s = !s2_valid_q || out_ready;
    in_ready = !s1_q.valid || s2_adv_s;
    xfer_s   = s2_valid_q && out_ready;

    // Clear takes effect first, so a coincident accumulating transfer leaves r.
    acc_d = acc_q;
    if (xfer_s && s2_acc_en_q) begin
      acc_d = acc_clr ? s2_r_q : out_q;
    end else if (acc_clr) begin
      acc_d = {MW{1'b0}};
    end else begin
      acc_d = acc_q;
    end

    m_d = mask_we ? mask_in : m_q;

    // Idle beats load zeros so undriven operands never reach the datapath.
    s1_d = s1_q;
    if (in_ready) begin
      if (in_valid) begin
        s1_d.valid  = 1'b1;
        s1_d.acc_en = acc_en;
        s1_d.x      = MW'(in1 ^ in2);
        s1_d.am     = MW'(in2 & m_q);
        s1_d.m      = MW'(m_q);
      end else begin
        s1_d = '0;
      end
    end else begin
      s1_d = s1_q;
    end

    // The presented value is fixed on entry to S2 using the post-edge acc.
    s2_valid_d  = s2_valid_q;
    s2_acc_en_d = s2_acc_en_q;
    s2_r_d      = s2_r_q;
    out_d       = out_q;
    if (s2_adv_s) begin
      s2_valid_d  = s1_q.valid;
      s2_acc_en_d = s1_q.acc_en;
      s2_r_d      = r_s;
      if (!s1_q.valid) begin
        out_d = {MW{1'b0}};
      end else if (s1_q.acc_en) begin
        out_d = acc_d ^ r_s;
      end else begin
        out_d = r_s;
      end
    end else begin
      out_d = out_q;
    end
    parity_d = parity_of(out_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q         <= {WIDTH{1'b1}};
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_acc_en_q <= 1'b0;
      s2_r_q      <= {MW{1'b0}};
      out_q       <= {MW{1'b0}};
      parity_q    <= 1'b0;
      acc_q       <= {MW{1'b0}};
    end else begin
      m_q         <= m_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_acc_en_q <= s2_acc_en_d;
      s2_r_q      <= s2_r_d;
      out_q       <= out_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q[WIDTH-1:0];
  assign parity    = parity_q;

endmodule

// File: tb/tb_xor_mask_pipe.sv
// Self-checking bench for xor_mask_pipe: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_xor_mask_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, mask_we, acc_en, acc_clr;
  logic         out_valid, out_ready, parity;
  logic [W-1:0] in1, in2, mask_in, out;

  always #5 clk = ~clk;

  xor_mask_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .parity    (parity)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         acc_en;
    int           t;
  } beat_t;

  beat_t        q[$];
  logic [W-1:0] seen[$];
  logic [W-1:0] m_mdl, acc_mdl, pval;
  bit           presented;
  int           cyc, n_chk, n_pass, n_hs;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic tick();
    logic  exp_rdy, exp_vld, accept, xfer;
    beat_t b;
    #1;
    if (rst_n) begin
      exp_rdy = (q.size() < 2) || out_ready;
      exp_vld = (q.size() > 0) && ((cyc - q[0].t) >= 2);
      check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
      check_eq("out_valid", 64'(out_valid), 64'(exp_vld));
      if (exp_vld) begin
        if (!presented) begin
          pval      = q[0].acc_en ? (acc_mdl ^ q[0].r) : q[0].r;
          presented = 1'b1;
        end
        check_eq("out", 64'(out), 64'(pval));
        check_eq("parity", 64'(parity), 64'(^pval));
      end else begin
        check_eq("out_idle", 64'(out), 64'd0);
        check_eq("parity_idle", 64'(parity), 64'd0);
      end
      if (in_valid && in_ready) n_hs++;
      accept = in_valid && exp_rdy;
      xfer   = exp_vld && out_ready;
      if (xfer) begin
        b = q.pop_front();
        seen.push_back(pval);
        presented = 1'b0;
        if (b.acc_en) acc_mdl = acc_clr ? b.r : pval;
        else if (acc_clr) acc_mdl = '0;
      end else if (acc_clr) begin
        acc_mdl = '0;
      end
      if (accept) q.push_back('{r: in1 & m_mdl, acc_en: acc_en, t: cyc});
      if (mask_we) m_mdl = mask_in;
    end else begin
      q.delete();
      acc_mdl   = '0;
      m_mdl     = '1;
      presented = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    mask_we  = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ae);
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    acc_en   = ae;
  endtask

  task automatic expect_seen(input string tag, input int idx, input logic [W-1:0] v);
    if (idx < seen.size()) check_eq(tag, 64'(seen[idx]), 64'(v));
    else check_eq({tag, "_missing"}, 64'(seen.size()), 64'(idx + 1));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_hs = 0; cyc = 0;
    presented = 1'b0; acc_mdl = '0; m_mdl = '1; pval = '0;
    rst_n = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; mask_in = '0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic
    seen.delete();
    beat(8'hA5, 8'h3C, 1'b0); tick(); idle(); repeat (3) tick();
    check_eq("basic_count", 64'(seen.size()), 64'd1);
    expect_seen("basic_out", 0, 8'hA5);

    // Mask: beat with mask_we keeps old mask, next beat uses new one
    seen.delete();
    beat(8'hA5, 8'h3C, 1'b0); mask_we = 1'b1; mask_in = 8'h0F; tick();
    idle(); beat(8'hA5, 8'h3C, 1'b0); tick(); idle(); repeat (3) tick();
    expect_seen("mask_old", 0, 8'hA5);
    expect_seen("mask_new", 1, 8'h05);
    mask_we = 1'b1; mask_in = 8'hFF; tick(); idle();

    // Accumulate, clear coincident with third transfer
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    seen.delete();
    beat(8'h01, 8'h00, 1'b1); tick();
    beat(8'h02, 8'h00, 1'b1); tick();
    beat(8'h04, 8'h00, 1'b1); tick();
    idle(); tick();
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    beat(8'h00, 8'h00, 1'b1); tick(); idle(); repeat (3) tick();
    expect_seen("acc_1", 0, 8'h01);
    expect_seen("acc_2", 1, 8'h03);
    expect_seen("acc_3", 2, 8'h07);
    expect_seen("acc_after_clr", 3, 8'h04);

    // Backpressure
    seen.delete(); n_hs = 0; out_ready = 1'b0;
    beat(8'h10, 8'h00, 1'b0); tick();
    beat(8'h20, 8'h00, 1'b0); tick();
    beat(8'h30, 8'h00, 1'b0); repeat (3) tick();
    check_eq("bp_accepted", 64'(n_hs), 64'd2);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1; tick(); idle(); repeat (4) tick();
    check_eq("bp_total", 64'(n_hs), 64'd3);
    expect_seen("bp_1", 0, 8'h10);
    expect_seen("bp_2", 1, 8'h20);
    expect_seen("bp_3", 2, 8'h30);

    // Reset with both stages full and acc=0x5A
    acc_clr = 1'b1; beat(8'h5A, 8'h00, 1'b1); tick(); idle(); repeat (3) tick();
    mask_we = 1'b1; mask_in = 8'h33; tick(); idle();
    out_ready = 1'b0;
    beat(8'h01, 8'h02, 1'b1); tick();
    beat(8'h03, 8'h04, 1'b1); tick();
    idle(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; out_ready = 1'b1;
    seen.delete();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    beat(8'h11, W'($urandom), 1'b1); tick(); idle(); repeat (3) tick();
    check_eq("rst_count", 64'(seen.size()), 64'd1);
    expect_seen("rst_after", 0, 8'h11);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(99) != 0);
      in_valid  = $urandom_range(1);
      in1       = W'($urandom);
      in2       = W'($urandom);
      acc_en    = $urandom_range(1);
      acc_clr   = ($urandom_range(7) == 0);
      mask_we   = ($urandom_range(7) == 0);
      mask_in   = W'($urandom);
      out_ready = ($urandom_range(3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
